// File: rtl/maze_map.sv
// Tile map for a maze game: read-only tile image plus a writable 2-bit pellet
// store, a registered display/player read path and a pellet-eating port.
module maze_map #(
  parameter int COLS = 40,
  parameter int ROWS = 30,
  parameter int DATA_W = 7,
  parameter logic [COLS*ROWS*DATA_W-1:0] INIT_IMAGE = '0,
  localparam int N = COLS * ROWS,
  localparam int AW = $clog2(N)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_restart,
  input  logic [AW-1:0]     i_vga_index,
  output logic [DATA_W-1:0] o_vga_tile,
  input  logic [AW-1:0]     i_pac_index,
  output logic [3:0]        o_pac_adjacent,
  input  logic              i_eat_req,
  output logic              o_eat_done,
  output logic              o_eat_hit,
  output logic              o_eat_power,
  output logic [AW:0]       o_pellets_left,
  output logic              o_ready,
  output logic              o_level_clear,
  output logic              o_dbg_state
);

  typedef enum logic {S_INIT = 1'b0, S_READY = 1'b1} state_t;

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  // Word i of the image sits at INIT_IMAGE[i*DATA_W +: DATA_W].
  function automatic logic [DATA_W-1:0] img_word(input logic [AW-1:0] idx);
    return INIT_IMAGE[int'(idx)*DATA_W +: DATA_W];
  endfunction

  function automatic logic [1:0] img_pellets(input logic [AW-1:0] idx);
    return INIT_IMAGE[int'(idx)*DATA_W + 5 +: 2];
  endfunction

  function automatic logic [3:0] img_adjacent(input logic [AW-1:0] idx);
    return INIT_IMAGE[int'(idx)*DATA_W + 1 +: 4];
  endfunction

  state_t            r_state;
  logic [AW-1:0]     r_scan_addr;
  logic [AW:0]       r_pellets_left;
  logic              r_ready;
  logic              r_eat_done;
  logic              r_eat_hit;
  logic              r_eat_power;
  logic [DATA_W-1:0] r_vga_tile;
  logic [3:0]        r_pac_adj;
  logic [1:0]        r_pellet [0:N-1];

  logic              w_vga_in;
  logic              w_pac_in;
  logic [1:0]        w_scan_pel;
  logic [DATA_W-1:0] w_vga_word;
  logic [3:0]        w_pac_adj;
  logic [1:0]        w_pac_pel;

  assign w_vga_in = (i_vga_index <= LAST);
  assign w_pac_in = (i_pac_index <= LAST);

  always_comb begin
    w_scan_pel = img_pellets(r_scan_addr);
    w_vga_word = '0;
    w_pac_adj  = 4'b1111;
    w_pac_pel  = 2'b00;
    // Off-map indices read as a solid wall with no pellets.
    if (w_vga_in) begin
      w_vga_word      = img_word(i_vga_index);
      w_vga_word[6:5] = r_pellet[i_vga_index];
    end else begin
      w_vga_word[4:0] = 5'b11111;
    end
    if (w_pac_in) begin
      w_pac_adj = img_adjacent(i_pac_index);
      w_pac_pel = r_pellet[i_pac_index];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_restart) begin
      r_state        <= S_INIT;
      r_scan_addr    <= '0;
      r_pellets_left <= '0;
      r_ready        <= 1'b0;
      r_eat_done     <= 1'b0;
      r_eat_hit      <= 1'b0;
      r_eat_power    <= 1'b0;
      // A restart keeps the display path alive; only a full reset blanks it.
      if (i_reset) begin
        r_vga_tile <= '0;
        r_pac_adj  <= '0;
      end else begin
        r_vga_tile <= w_vga_word;
        r_pac_adj  <= w_pac_adj;
      end
    end else begin
      r_vga_tile  <= w_vga_word;
      r_pac_adj   <= w_pac_adj;
      r_eat_done  <= 1'b0;
      r_eat_hit   <= 1'b0;
      r_eat_power <= 1'b0;
      case (r_state)
        S_INIT: begin
          r_pellet[r_scan_addr] <= w_scan_pel;
          if (|w_scan_pel) r_pellets_left <= r_pellets_left + (AW+1)'(1);
          if (r_scan_addr == LAST) begin
            r_state <= S_READY;
            r_ready <= 1'b1;
          end else begin
            r_scan_addr <= r_scan_addr + AW'(1);
          end
        end
        S_READY: begin
          if (i_eat_req) begin
            r_eat_done  <= 1'b1;
            r_eat_hit   <= |w_pac_pel;
            r_eat_power <= w_pac_pel[1];
            if (|w_pac_pel) begin
              r_pellet[i_pac_index] <= 2'b00;
              if (r_pellets_left != '0) r_pellets_left <= r_pellets_left - (AW+1)'(1);
            end
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign o_vga_tile     = r_vga_tile;
  assign o_pac_adjacent = r_pac_adj;
  assign o_eat_done     = r_eat_done;
  assign o_eat_hit      = r_eat_hit;
  assign o_eat_power    = r_eat_power;
  assign o_pellets_left = r_pellets_left;
  assign o_ready        = r_ready;
  assign o_level_clear  = r_ready && (r_pellets_left == '0);
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_maze_map.sv
// Bench for maze_map: builds a known tile image, checks reset/init timing,
// table-driven reads, hand-written eat sequences and a randomized run.
module tb_maze_map;
  localparam int COLS = 40;
  localparam int ROWS = 30;
  localparam int DW = 7;
  localparam int N = COLS * ROWS;
  localparam int AW = $clog2(N);

  // Image rule: 3 pellets (7, 100, N-1), 1 power pellet (20), varied walls.
  function automatic logic [6:0] tile_rule(int i);
    logic [6:0] w;
    w = '0;
    w[0]   = (i % 7 == 3);
    w[4:1] = 4'((i * 5 + 3) % 16);
    w[5]   = (i == 7 || i == 100 || i == N - 1);
    w[6]   = (i == 20);
    return w;
  endfunction

  function automatic logic [N*DW-1:0] build_image();
    logic [N*DW-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        v[(r*COLS+c)*DW +: DW] = tile_rule(r * COLS + c);
    return v;
  endfunction

  localparam logic [N*DW-1:0] IMG = build_image();

  logic          clk = 1'b0;
  logic          reset, restart, eat_req;
  logic [AW-1:0] vga_index, pac_index;
  logic [DW-1:0] vga_tile;
  logic [3:0]    pac_adjacent;
  logic          eat_done, eat_hit, eat_power, ready, level_clear, dbg_state;
  logic [AW:0]   pellets_left;

  always #5 clk = ~clk;

  maze_map #(.COLS(COLS), .ROWS(ROWS), .DATA_W(DW), .INIT_IMAGE(IMG)) dut (
    .i_clk(clk), .i_reset(reset), .i_restart(restart),
    .i_vga_index(vga_index), .o_vga_tile(vga_tile),
    .i_pac_index(pac_index), .o_pac_adjacent(pac_adjacent),
    .i_eat_req(eat_req), .o_eat_done(eat_done), .o_eat_hit(eat_hit),
    .o_eat_power(eat_power), .o_pellets_left(pellets_left),
    .o_ready(ready), .o_level_clear(level_clear), .o_dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] m_pel [N];
  int m_left;
  logic [1:0] exp_q [$];

  typedef struct {
    int vga;
    int pac;
    logic [6:0] exp_tile;
    logic [3:0] exp_adj;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_init();
    logic [6:0] w;
    m_left = 0;
    for (int i = 0; i < N; i++) begin
      w = tile_rule(i);
      m_pel[i] = w[6:5];
      if (w[6:5] != 2'b00) m_left++;
    end
  endtask

  function automatic logic [6:0] model_tile(int idx);
    logic [6:0] w;
    if (idx >= N) return 7'b0011111;
    w = tile_rule(idx);
    w[6:5] = m_pel[idx];
    return w;
  endfunction

  function automatic logic [3:0] adj_of(int idx);
    logic [6:0] w;
    if (idx >= N) return 4'b1111;
    w = tile_rule(idx);
    return w[4:1];
  endfunction

  task automatic model_eat(input int idx, output logic hit, output logic pw);
    hit = 1'b0;
    pw  = 1'b0;
    if (idx < N && m_pel[idx] != 2'b00) begin
      hit = 1'b1;
      pw  = m_pel[idx][1];
      m_pel[idx] = 2'b00;
      if (m_left > 0) m_left--;
    end
  endtask

  // Counts edges until ready rises, bounded so a stuck DUT still terminates.
  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!ready && cyc < N + 20) begin
      step();
      cyc++;
    end
  endtask

  task automatic eat_check(input string nm, input int idx);
    logic h, p;
    pac_index = AW'(idx);
    eat_req = 1'b1;
    model_eat(idx, h, p);
    step();
    eat_req = 1'b0;
    check({nm, "_done"}, 32'(eat_done), 32'd1);
    check({nm, "_hit"}, 32'(eat_hit), 32'(h));
    check({nm, "_power"}, 32'(eat_power), 32'(p));
    check({nm, "_left"}, 32'(pellets_left), 32'(m_left));
    check({nm, "_clear"}, 32'(level_clear), 32'(m_left == 0));
  endtask

  function automatic int pick_pellet_tile();
    case ($urandom_range(0, 3))
      0: return 7;
      1: return 20;
      2: return 100;
      default: return N - 1;
    endcase
  endfunction

  task automatic random_run(input int cycles);
    int vi, pi;
    logic eq, h, p;
    logic [6:0] e_tile;
    logic [3:0] e_adj;
    logic [1:0] e;
    for (int k = 0; k < cycles; k++) begin
      vi = ($urandom_range(0, 1) == 1) ? pick_pellet_tile() : int'($urandom_range(0, 2047));
      pi = ($urandom_range(0, 1) == 1) ? pick_pellet_tile() : int'($urandom_range(0, 2047));
      eq = ($urandom_range(0, 2) == 0);
      vga_index = AW'(vi);
      pac_index = AW'(pi);
      eat_req = eq;
      e_tile = model_tile(vi);
      e_adj = adj_of(pi);
      if (eq) begin
        model_eat(pi, h, p);
        exp_q.push_back({h, p});
      end
      step();
      check("rnd_tile", 32'(vga_tile), 32'(e_tile));
      check("rnd_adj", 32'(pac_adjacent), 32'(e_adj));
      check("rnd_done", 32'(eat_done), 32'(eq));
      if (eat_done && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rnd_hit", 32'(eat_hit), 32'(e[1]));
        check("rnd_power", 32'(eat_power), 32'(e[0]));
      end
      check("rnd_left", 32'(pellets_left), 32'(m_left));
      check("rnd_clear", 32'(level_clear), 32'(m_left == 0));
    end
    eat_req = 1'b0;
    check("rnd_q_drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic h, p;

    tbl[0] = '{N + 5, N + 5, 7'b0011111, 4'b1111};
    tbl[1] = '{2047, 0, 7'b0011111, adj_of(0)};
    tbl[2] = '{0, N - 1, tile_rule(0), adj_of(N - 1)};
    tbl[3] = '{7, 20, tile_rule(7), adj_of(20)};
    tbl[4] = '{20, 7, tile_rule(20), adj_of(7)};
    tbl[5] = '{N - 1, 2047, tile_rule(N - 1), 4'b1111};
    tbl[6] = '{100, N, tile_rule(100), 4'b1111};
    tbl[7] = '{3, 100, tile_rule(3), adj_of(100)};

    reset = 1'b1; restart = 1'b0; eat_req = 1'b0;
    vga_index = '0; pac_index = '0;

    // Reset values and init timing.
    step();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_left", 32'(pellets_left), 32'd0);
    check("rst_clear", 32'(level_clear), 32'd0);
    check("rst_done", 32'(eat_done), 32'd0);
    check("rst_hit", 32'(eat_hit), 32'd0);
    check("rst_power", 32'(eat_power), 32'd0);
    check("rst_vga", 32'(vga_tile), 32'd0);
    check("rst_adj", 32'(pac_adjacent), 32'd0);
    reset = 1'b0;
    wait_ready(cyc);
    check("init_cycles", 32'(cyc), 32'(N));
    check("init_left", 32'(pellets_left), 32'd4);
    check("init_clear", 32'(level_clear), 32'd0);
    model_init();

    // Read paths, including off-map indices.
    for (int i = 0; i < 8; i++) begin
      vga_index = AW'(tbl[i].vga);
      pac_index = AW'(tbl[i].pac);
      step();
      check($sformatf("tbl%0d_tile", i), 32'(vga_tile), 32'(tbl[i].exp_tile));
      check($sformatf("tbl%0d_adj", i), 32'(pac_adjacent), 32'(tbl[i].exp_adj));
    end

    // Power tile eaten twice on consecutive cycles.
    pac_index = AW'(20);
    eat_req = 1'b1;
    model_eat(20, h, p);
    step();
    check("burst1_done", 32'(eat_done), 32'd1);
    check("burst1_hit", 32'(eat_hit), 32'd1);
    check("burst1_power", 32'(eat_power), 32'd1);
    check("burst1_left", 32'(pellets_left), 32'd3);
    model_eat(20, h, p);
    step();
    eat_req = 1'b0;
    check("burst2_done", 32'(eat_done), 32'd1);
    check("burst2_hit", 32'(eat_hit), 32'd0);
    check("burst2_left", 32'(pellets_left), 32'd3);

    // Display read of a tile across the edge that eats it.
    vga_index = AW'(7);
    pac_index = AW'(7);
    eat_req = 1'b1;
    model_eat(7, h, p);
    step();
    eat_req = 1'b0;
    check("vga7_before", 32'(vga_tile[6:5]), 32'b01);
    check("vga7_eat_hit", 32'(eat_hit), 32'd1);
    step();
    check("vga7_after", 32'(vga_tile[6:5]), 32'b00);
    check("vga7_tile", 32'(vga_tile), 32'(model_tile(7)));

    // Off-map eat, then clear the level and eat once more.
    eat_check("eat_offmap", 1500);
    eat_check("eat_100", 100);
    eat_check("eat_last", N - 1);
    check("clear_left", 32'(pellets_left), 32'd0);
    check("clear_flag", 32'(level_clear), 32'd1);
    eat_check("eat_empty", 100);

    // restart and eat_req together: restart wins, eat in INIT dropped.
    pac_index = AW'(7);
    restart = 1'b1;
    eat_req = 1'b1;
    step();
    restart = 1'b0;
    eat_req = 1'b0;
    check("rs_done", 32'(eat_done), 32'd0);
    check("rs_ready", 32'(ready), 32'd0);
    check("rs_left", 32'(pellets_left), 32'd0);
    check("rs_clear", 32'(level_clear), 32'd0);
    pac_index = AW'(20);
    eat_req = 1'b1;
    step();
    eat_req = 1'b0;
    check("init_eat_drop", 32'(eat_done), 32'd0);
    wait_ready(cyc);
    check("rs_cycles", 32'(cyc + 1), 32'(N));
    check("rs_left4", 32'(pellets_left), 32'd4);
    model_init();

    random_run(250);

    // restart in the middle of INIT rescans from 0.
    restart = 1'b1;
    step();
    restart = 1'b0;
    repeat (300) step();
    check("mid_rs_ready", 32'(ready), 32'd0);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("mid_rs_left", 32'(pellets_left), 32'd0);
    wait_ready(cyc);
    check("mid_rs_cycles", 32'(cyc), 32'(N));
    check("mid_rs_left4", 32'(pellets_left), 32'd4);
    model_init();

    // Reset once the scan has reached address 500.
    restart = 1'b1;
    step();
    restart = 1'b0;
    repeat (500) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_left", 32'(pellets_left), 32'd0);
    check("mid_rst_vga", 32'(vga_tile), 32'd0);
    wait_ready(cyc);
    check("mid_rst_cycles", 32'(cyc), 32'(N));
    check("mid_rst_left4", 32'(pellets_left), 32'd4);
    model_init();

    random_run(250);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/maze_map.md
MAZE_MAP -- requirements
Module: maze_map

Interface
REQ-001 Parameters: COLS=40 (tile columns); ROWS=30 (tile rows); DATA_W=7 (tile word width, min 7); INIT_FILE="../misc/maze_7bit.txt" (binary tile image, COLS*ROWS words); N=COLS*ROWS, AW=clog2(N) are derived.
REQ-002 Tile word bit map: [0] wall; [4:1] adjacent walls (up, down, left, right); [5] pellet; [6] power pellet; bits above 6 are reserved and pass through unchanged.
REQ-003 Clk  in  1  system clock; all state changes on its rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 restart  in  1  pulse; reloads all pellets (new level) without a full reset.
REQ-006 vga_index  in  AW  tile index requested by the display path.
REQ-007 vga_tile  out  DATA_W  live tile word for vga_index; pellet bits reflect eaten state.
REQ-008 pac_index  in  AW  tile index of the player.
REQ-009 pac_adjacent  out  4  adjacent-wall bits [4:1] for pac_index.
REQ-010 eat_req  in  1  pulse; consume the pellet at pac_index.
REQ-011 eat_done  out  1  one-cycle pulse acknowledging an accepted eat_req.
REQ-012 eat_hit, eat_power  out  1 each  with eat_done: a pellet was present / it was a power pellet.
REQ-013 pellets_left  out  AW+1  count of remaining pellets (normal and power).
REQ-014 ready  out  1  high when the map is initialised and accepting eats.
REQ-015 level_clear  out  1  equals ready AND (pellets_left==0).

Function
REQ-016 Storage SHALL consist of a read-only tile image loaded from INIT_FILE plus a writable 2-bit-per-tile pellet store.
REQ-017 FSM states SHALL be INIT and READY; Reset or restart SHALL force INIT with scan address 0 and pellets_left 0.
REQ-018 In INIT, the block SHALL copy image bits [6:5] into the pellet store for one address per cycle, add 1 to pellets_left when either bit is set, and enter READY after address N-1 (N cycles in total).
REQ-019 ready SHALL be 0 in INIT and 1 in READY.
REQ-020 vga_tile and pac_adjacent SHALL be registered, with 1-cycle latency; both SHALL be valid in every state.
REQ-021 vga_tile[6:5] SHALL come from the pellet store; the other bits SHALL come from the image.
REQ-022 An index >= N SHALL read as wall=1, adjacent=4'b1111, no pellets, reserved bits 0.
REQ-023 An eat_req sampled in READY with restart=0 SHALL produce eat_done=1 on the next edge.
REQ-024 On that edge, eat_hit and eat_power SHALL reflect the pellet state before the eat.
REQ-025 On a hit, the tile's pellet bits SHALL clear and pellets_left SHALL decrement by 1 on the same edge as eat_done.
REQ-026 A miss SHALL leave the pellet store and pellets_left unchanged.
REQ-027 An eat_req in INIT, or with restart high in the same cycle, SHALL be dropped with no eat_done; restart wins.
REQ-028 An eat_req with pac_index >= N SHALL ack with eat_hit=0.
REQ-029 Back-to-back eat_req on consecutive cycles SHALL each ack; a repeat on the same index SHALL see the cleared state (eat_hit=0), using forwarding if the store is RAM.
REQ-030 A vga read of an index eaten on the previous edge SHALL return the cleared pellet bits.
REQ-031 pellets_left SHALL never underflow and SHALL saturate at 0.
REQ-032 restart mid-INIT SHALL restart the scan from address 0.

Reset
REQ-033 On Reset: state=INIT, scan address=0, pellets_left=0, ready=0, level_clear=0, eat_done=0, eat_hit=0, eat_power=0, vga_tile=0, pac_adjacent=0.
REQ-034 Contents of the pellet store are don't-care until INIT completes.

Verification
REQ-035 Reset with an image of 3 pellets plus 1 power pellet -> ready rises exactly N cycles after Reset falls; pellets_left=4; level_clear=0.
REQ-036 Eat on a power tile, then the same tile on the next cycle -> first: eat_done=1, eat_hit=1, eat_power=1, pellets_left=3; second: eat_hit=0, pellets_left=3.
REQ-037 Eat all 4 pellets -> pellets_left=0 and level_clear=1; one further eat -> eat_hit=0 and pellets_left stays 0.
REQ-038 restart and eat_req asserted in the same cycle -> no eat_done; INIT rescans and pellets_left returns to 4 after N cycles.
REQ-039 vga_index=N+5 -> vga_tile wall=1, adjacent=1111, pellets=00; eat the tile at vga_index=7 -> the next vga read of 7 shows bits [6:5]=00.
REQ-040 Reset asserted mid-INIT at address 500 -> ready=0 and the scan restarts at 0; the final count matches the image.
